// File: rtl/pcie_lane_scrambler.sv
// pcie_lane_scrambler: multi-lane Galois-LFSR scrambler/descrambler with a
// one-deep valid/ready output register. Each lane advances DATA_W bit-steps per
// accepted beat, with per-lane hold/bypass and a shared reseed.
// Optional statistics counters are enabled by defining PCIE_LANE_SCR_STATS_EN.
module pcie_lane_scrambler #(
  parameter int                LANES  = 4,
  parameter int                DATA_W = 32,
  parameter int                LFSR_W = 16,
  parameter logic [LFSR_W-1:0] POLY   = 16'h0039,
  parameter logic [LFSR_W-1:0] SEED   = 16'hFFFF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  input  logic [LANES-1:0]        in_bypass,
  input  logic [LANES-1:0]        in_hold,
  input  logic                    in_reseed,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] out_data
`ifdef PCIE_LANE_SCR_STATS_EN
  ,
  output logic [31:0]             stat_beats,
  output logic [15:0]             stat_reseeds
`endif
);

  localparam int ADV_W = LFSR_W + DATA_W;

  // Unrolled DATA_W Galois steps: returns {keystream, end state}; keystream
  // bit i is the MSB shifted out on step i.
  function automatic logic [ADV_W-1:0] lfsr_advance(input logic [LFSR_W-1:0] start);
    logic [LFSR_W-1:0] s;
    logic [DATA_W-1:0] ks;
    logic              k;
    s  = start;
    ks = '0;
    for (int i = 0; i < DATA_W; i++) begin
      k     = s[LFSR_W-1];
      ks[i] = k;
      s     = {s[LFSR_W-2:0], 1'b0} ^ (k ? POLY : '0);
    end
    return {ks, s};
  endfunction

  logic                    accept;
  logic                    vld_p1;
  logic [LANES*DATA_W-1:0] data_p1;
  logic [LANES*DATA_W-1:0] data_nxt;

  // A stalled output register blocks input; ready is combinational from out_ready.
  assign in_ready  = !vld_p1 || out_ready;
  assign accept    = in_valid && in_ready;
  assign out_valid = vld_p1;
  assign out_data  = data_p1;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [LFSR_W-1:0] lfsr_p0;
    logic [LFSR_W-1:0] lfsr_nxt;
    logic [LFSR_W-1:0] start;
    logic [ADV_W-1:0]  adv;
    logic [DATA_W-1:0] lane_in;
    logic [DATA_W-1:0] lane_out;

    assign start   = in_reseed ? SEED : lfsr_p0;
    assign adv     = lfsr_advance(start);
    assign lane_in = in_data[l*DATA_W +: DATA_W];

    // Lane select: hold freezes at the (possibly reseeded) start value, bypass
    // advances without applying the keystream, otherwise scramble.
    always_comb begin
      lfsr_nxt = adv[LFSR_W-1:0];
      lane_out = lane_in ^ adv[ADV_W-1:LFSR_W];
      if (in_hold[l]) begin
        lfsr_nxt = start;
        lane_out = lane_in;
      end else if (in_bypass[l]) begin
        lane_out = lane_in;
      end
    end

    assign data_nxt[l*DATA_W +: DATA_W] = lane_out;

    // Lane LFSR state: moves only on an accepted beat.
    always_ff @(posedge clk) begin
      if (rst) begin
        lfsr_p0 <= SEED;
      end else if (accept) begin
        lfsr_p0 <= lfsr_nxt;
      end
    end
  end

  // ---- stage p0 -> p1: output register ----
  // Load on accept, hold while stalled, clear valid after a drain-only handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else if (accept) begin
      vld_p1  <= 1'b1;
      data_p1 <= data_nxt;
    end else if (out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

`ifdef PCIE_LANE_SCR_STATS_EN
  // Beat counter wraps; reseed counter saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_beats   <= '0;
      stat_reseeds <= '0;
    end else if (accept) begin
      stat_beats <= stat_beats + 32'd1;
      if (in_reseed && (stat_reseeds != 16'hFFFF)) begin
        stat_reseeds <= stat_reseeds + 16'd1;
      end
    end
  end
`endif

endmodule
